// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and widths for the memory access sequencer.
// Build option: MEM_BURST_EN enables multi-beat bursts.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BURST_MAX = 4;
  localparam int unsigned BEATS_W   = $clog2(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Control-unit request bus and data-memory bus seen by the sequencer.
// The slave modport is the sequencer; master is the requester plus memory.
interface mem_access_ctrl_if;
  import cpu_mem_pkg::*;

  logic               req;
  logic               rw;
  logic [ADDR_W-1:0]  addr;
  logic [BEATS_W-1:0] burst_len;
  logic [DATA_W-1:0]  wdata;
  logic               busy;
  logic               done;
  logic               wtake;
  logic [DATA_W-1:0]  rdata;
  logic               rvalid;
  logic               mem_cs;
  logic               mem_we;
  logic               mem_oe;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_dio;

  modport slave (
    input  req, rw, addr, burst_len, wdata, mem_dio,
    output busy, done, wtake, rdata, rvalid,
    output mem_cs, mem_we, mem_oe, mem_addr, mem_wdata
  );

  modport master (
    output req, rw, addr, burst_len, wdata, mem_dio,
    input  busy, done, wtake, rdata, rvalid,
    input  mem_cs, mem_we, mem_oe, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_access_ctrl_addr_seq.sv
// MAR loader with wrapping increment and remaining-beat counter.
// Without MEM_BURST_EN it only loads the start address; every request is one beat.
module mem_addr_seq
  import cpu_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [BEATS_W-1:0] len_in,
  output logic [ADDR_W-1:0]  mar,
  output logic               last
);

  logic [ADDR_W-1:0] mar_q, mar_d;

`ifdef MEM_BURST_EN
  logic [BEATS_W-1:0] beats_q, beats_d;

  always_comb begin
    mar_d   = mar_q;
    beats_d = beats_q;
    if (load) begin
      mar_d   = addr_in;
      beats_d = len_in;
    end else if (advance) begin
      mar_d   = mar_q + ADDR_W'(1);
      beats_d = beats_q - BEATS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar_q   <= '0;
      beats_q <= '0;
    end else begin
      mar_q   <= mar_d;
      beats_q <= beats_d;
    end
  end

  assign last = (beats_q == '0);
`else
  logic unused_burst;

  always_comb begin
    mar_d = mar_q;
    if (load) mar_d = addr_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mar_q <= '0;
    else     mar_q <= mar_d;
  end

  assign unused_burst = ^{advance, len_in};
  assign last         = 1'b1;
`endif

  assign mar = mar_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between the control unit and the 256x16 data memory: two cycles
// per beat (SETUP, ACCESS), then a one-cycle DONE. Build option: MEM_BURST_EN.
module mem_access_ctrl
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              wtake_q, wtake_d;
  logic              rvalid_q, rvalid_d;
  logic              load;
  logic              advance;
  logic              last;
  logic [ADDR_W-1:0] mar;

  mem_addr_seq u_addr_seq (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .addr_in (bus.addr),
    .len_in  (bus.burst_len),
    .mar     (mar),
    .last    (last)
  );

  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    mdr_d    = mdr_q;
    wtake_d  = 1'b0;
    rvalid_d = 1'b0;
    load     = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          load    = 1'b1;
          rw_d    = bus.rw;
          state_d = SETUP;
          if (bus.rw) begin
            mdr_d   = bus.wdata;
            wtake_d = 1'b1;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (!rw_q) begin
          mdr_d    = bus.mem_dio;
          rvalid_d = 1'b1;
        end
        if (!last) begin
          advance = 1'b1;
          state_d = SETUP;
          // Next write word is handed off on the same edge the current one commits.
          if (rw_q) begin
            mdr_d   = bus.wdata;
            wtake_d = 1'b1;
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rw_q     <= 1'b0;
      mdr_q    <= '0;
      wtake_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      mdr_q    <= mdr_d;
      wtake_q  <= wtake_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Memory strobes decode from registered state only, so we/oe are exclusive by construction.
  assign bus.mem_cs    = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.mem_oe    = bus.mem_cs && !rw_q;
  assign bus.mem_we    = (state_q == ACCESS) && rw_q;
  assign bus.mem_addr  = mar;
  assign bus.mem_wdata = mdr_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.wtake     = wtake_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl with a 256x16 memory
// and a request-level reference model; honours MEM_BURST_EN.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] mem     [256] = '{default: '0};
  logic [15:0] ref_mem [256] = '{default: '0};

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_dio = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_cs && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int beats_for(input logic [1:0] bl);
`ifdef MEM_BURST_EN
    return int'(bl) + 1;
`else
    return (bl == 2'd0) ? 1 : 1;
`endif
  endfunction

  // One request; expectations follow the 2-cycles-per-beat timeline from acceptance.
  task automatic run_req(input bit w, input logic [7:0] a, input logic [1:0] bl,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3,
                         input bit hold);
    logic [15:0] words [4];
    int          n;
    logic [7:0]  ea;
    bit          seen;
    words = '{d0, d1, d2, d3};
    n = beats_for(bl);
    @(negedge clk);
    bus.req = 1'b1; bus.rw = w; bus.addr = a; bus.burst_len = bl; bus.wdata = d0;
    for (int c = 1; c <= 2 * n + 1; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) bus.req = 1'b0;
      check_eq("busy", bus.busy, 1'b1);
      check_eq("done", bus.done, c == 2 * n + 1);
      check_eq("mem_cs", bus.mem_cs, c < 2 * n + 1);
      check_eq("mem_we", bus.mem_we, w && c < 2 * n + 1 && (c % 2 == 0));
      check_eq("mem_oe", bus.mem_oe, !w && c < 2 * n + 1);
      check_eq("wtake", bus.wtake, w && (c % 2 == 1) && c < 2 * n + 1);
      check_eq("rvalid", bus.rvalid, !w && c >= 3 && (c % 2 == 1));
      if (c < 2 * n + 1) begin
        ea = a + 8'((c - 1) / 2);
        check_eq("mem_addr", bus.mem_addr, ea);
        if (w && (c % 2 == 0)) check_eq("mem_wdata", bus.mem_wdata, words[(c - 2) / 2]);
      end
      if (!w && c >= 3 && (c % 2 == 1)) begin
        ea = a + 8'((c - 3) / 2);
        check_eq("rdata", bus.rdata, ref_mem[ea]);
      end
      if (w && (c % 2 == 1) && ((c + 1) / 2) < n) bus.wdata = words[(c + 1) / 2];
    end
    @(negedge clk);
    check_eq("busy_after", bus.busy, 1'b0);
    if (w) begin
      for (int k = 0; k < n; k++) ref_mem[8'(a + 8'(k))] = words[k];
    end
    if (hold) begin
      @(negedge clk);
      check_eq("hold_restart", bus.busy, 1'b1);
      bus.req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (bus.done) seen = 1'b1;
      end
      check_eq("hold_done_seen", seen, 1'b1);
      @(negedge clk);
      check_eq("hold_idle", bus.busy, 1'b0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, bus.busy, 1'b0);
    check_eq({tag, "_done"}, bus.done, 1'b0);
    check_eq({tag, "_wtake"}, bus.wtake, 1'b0);
    check_eq({tag, "_rvalid"}, bus.rvalid, 1'b0);
    check_eq({tag, "_cs"}, bus.mem_cs, 1'b0);
    check_eq({tag, "_we"}, bus.mem_we, 1'b0);
    check_eq({tag, "_oe"}, bus.mem_oe, 1'b0);
    check_eq({tag, "_rdata"}, bus.rdata, 16'h0);
    check_eq({tag, "_addr"}, bus.mem_addr, 8'h0);
    check_eq({tag, "_wdata"}, bus.mem_wdata, 16'h0);
  endtask

  initial begin
    logic [15:0] r [4];
    rst = 1'b1;
    bus.req = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.burst_len = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    run_req(1'b1, 8'h05, 2'd0, 16'hBEEF, 16'h0, 16'h0, 16'h0, 1'b0);
    run_req(1'b0, 8'h05, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

    run_req(1'b1, 8'hFE, 2'd3, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
    run_req(1'b0, 8'hFE, 2'd3, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

    run_req(1'b0, 8'h05, 2'd1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);

    @(negedge clk);
    bus.req = 1'b1; bus.rw = 1'b1; bus.addr = 8'h10; bus.burst_len = 2'd0; bus.wdata = 16'hAAAA;
    @(posedge clk);
    #1;
    check_eq("rst_setup_cs", bus.mem_cs, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_cs", bus.mem_cs, 1'b0);
    check_eq("rst_async_busy", bus.busy, 1'b0);
    check_eq("rst_async_we", bus.mem_we, 1'b0);
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_req(1'b0, 8'h10, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    check_eq("rst_no_write", mem[8'h10], 16'h0000);

    run_req(1'b1, 8'h21, 2'd0, 16'h5A5A, 16'h0, 16'h0, 16'h0, 1'b0);
    run_req(1'b1, 8'h20, 2'd3, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 1'b0);
    run_req(1'b0, 8'h21, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 4; k++) r[k] = 16'($urandom);
      run_req(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)),
              r[0], r[1], r[2], r[3], 1'b0);
    end

    for (int a = 0; a < 256; a++) check_eq("mem_contents", mem[a], ref_mem[a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
